debug_loader: RTL and testbench
===============================

# debug_loader

Host-facing controller that owns the instruction-fetch stage's memory write port and its halt/run sequencing. It consumes a byte stream from the UART receiver, loads programs byte-by-byte into instruction memory, and releases the pipeline for continuous run or single-step. It then reports each completed action with a one-byte acknowledge to the UART transmitter.

## Interface
- ADDR_WIDTH, 12, instruction memory byte-address width; maximum program length is 2^ADDR_WIDTH bytes.
- ACK, 8'h06, byte sent on successful completion.
- NAK, 8'h15, byte sent on rejected command or length.
- i_clk  in  1  single clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte; valid only in the cycle `i_rx_done` is high.
- i_rx_done  in  1  one-cycle strobe per received byte.
- i_tx_busy  in  1  transmitter busy.
- i_program_end  in  1  pipeline has retired its halt instruction; level.
- o_tx_data  out  8  byte to transmit; stable while `o_tx_start` is high.
- o_tx_start  out  1  one-cycle transmit strobe.
- o_write_instruction_mem  out  1  instruction memory write enable.
- o_instruction_mem_addr  out  32  write byte address; upper bits are zero.
- o_instruction_mem_data  out  32  write byte in [7:0]; [31:8] are zero.
- o_halt  out  1  freezes PC and fetch register when high.
- o_cpu_reset  out  1  active-high synchronous reset to the pipeline.

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, LOAD, RUN, STEP, SEND.
- IDLE accepts a command byte on `i_rx_done`:
  - 0x4C 'L': go to LEN_LO.
  - 0x52 'R': go to RUN, or to SEND with NAK if `i_program_end` is high.
  - 0x53 'S': go to STEP, or to SEND with NAK if `i_program_end` is high.
  - 0x50 'P': pulse `o_cpu_reset` for one cycle, then go to SEND with ACK.
  - Any other byte: go to SEND with NAK.
- LEN_LO/LEN_HI latch a 16-bit little-endian length N.
  - N=0 or N>2^ADDR_WIDTH: go to SEND with NAK; no memory write occurs.
  - Otherwise go to LOAD and clear the byte index to 0.
- LOAD: each `i_rx_done` writes `i_rx_data` to address = index, then increments the index.
  - After byte N-1 is written, go to SEND with ACK.
- `o_cpu_reset` is high in LEN_LO, LEN_HI and LOAD, so the PC restarts at 0 after a load.
- RUN: `o_halt` is low until `i_program_end` is sampled high, then go to SEND with ACK.
- STEP: `o_halt` is low for exactly one cycle, then go to SEND with ACK.
- SEND: wait for `i_tx_busy` low, pulse `o_tx_start` for one cycle with the pending byte, then return to IDLE.
- `o_halt` is high in every state except RUN and STEP.
- Bytes received in RUN, STEP or SEND are dropped and do not queue.
- `i_rx_done` in LEN_LO, LEN_HI and LOAD is consumed as data, even if its value matches a command code.

## Timing
- Reset values:
  - state IDLE
  - `o_halt`=1
  - `o_write_instruction_mem`=0
  - addr=0, data=0
  - `o_tx_start`=0, `o_tx_data`=0
  - `o_cpu_reset`=0
  - index=0, length=0
- All outputs are registered.
- Write latency: `o_write_instruction_mem` is high for exactly the one cycle after the `i_rx_done` strobe, with addr and data valid in that same cycle.
- Completion: SEND is entered the cycle after the last write, and `o_cpu_reset` drops in that same cycle.
- `o_tx_start` is asserted no earlier than the first cycle `i_tx_busy` is sampled low in SEND.
- RUN end: `o_halt` rises the cycle after `i_program_end` is sampled high.
- An asynchronous reset mid-LOAD aborts the load. Already-written bytes remain in memory. The next command must begin from IDLE.
- The index is an (ADDR_WIDTH+1)-bit counter, so N=2^ADDR_WIDTH fills addresses 0..4095 without wrap-around.

## Test plan
- Load: send 4C 04 00 11 22 33 44 -> four write pulses at addr 0..3 with data 0x11,0x22,0x33,0x44; `o_cpu_reset` high throughout; then a single `o_tx_start` with 0x06.
- Bad length: send 4C 00 00 -> no write pulses; `o_tx_data`=0x15.
- Then send 4C 01 10 -> NAK, since length 0x1001 exceeds 4096.
- Step: send 53 with `i_program_end`=0 -> `o_halt` low for exactly 1 cycle, then ACK 0x06.
- Run: send 52, raise `i_program_end` 20 cycles later -> `o_halt` low for 20 cycles, high the cycle after; ACK follows.
- Run rejected: send 52 with `i_program_end`=1 -> `o_halt` never drops; NAK.
- Backpressure and reset:
  - Hold `i_tx_busy`=1 for 10 cycles in SEND -> `o_tx_start` first pulses the cycle after `i_tx_busy` falls.
  - Assert `i_reset`=0 after 2 of 4 load bytes -> all outputs return to reset values; a following 0x50 yields one `o_cpu_reset` pulse and ACK.

Source files
------------

// File: rtl/debug_loader.sv
// Host-side loader: decodes UART command bytes, writes programs into instruction
// memory, sequences halt/run/step of the pipeline and acknowledges each action.
module debug_loader #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [7:0]  ACK        = 8'h06,
   parameter logic [7:0]  NAK        = 8'h15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_done,
   input  logic        i_tx_busy,
   input  logic        i_program_end,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_start,
   output logic        o_write_instruction_mem,
   output logic [31:0] o_instruction_mem_addr,
   output logic [31:0] o_instruction_mem_data,
   output logic        o_halt,
   output logic        o_cpu_reset,
   output logic [2:0]  o_debug_state
);

   // Handshake: i_rx_done is a one-cycle strobe qualifying i_rx_data; o_tx_start
   // is a one-cycle strobe issued only after i_tx_busy is sampled low in SEND,
   // with o_tx_data held stable from that strobe until the next one.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      LOAD   = 3'd3,
      RUN    = 3'd4,
      STEP   = 3'd5,
      SEND   = 3'd6
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_WIDTH;

   state_t               state;
   logic [7:0]           pending;
   logic [15:0]          length;
   logic [ADDR_WIDTH:0]  index;
   logic [15:0]          len_next;
   logic [15:0]          index_ext;
   logic                 len_bad;

   assign len_next      = {i_rx_data, length[7:0]};
   assign len_bad       = (len_next == 16'd0) || ({1'b0, len_next} > MAX_LEN);
   assign index_ext     = 16'(index);
   assign o_debug_state = state;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state                   <= IDLE;
         pending                 <= 8'h00;
         length                  <= 16'd0;
         index                   <= '0;
         o_tx_data               <= 8'h00;
         o_tx_start              <= 1'b0;
         o_write_instruction_mem <= 1'b0;
         o_instruction_mem_addr  <= 32'd0;
         o_instruction_mem_data  <= 32'd0;
         o_halt                  <= 1'b1;
         o_cpu_reset             <= 1'b0;
      end else begin
         o_write_instruction_mem <= 1'b0;
         o_tx_start              <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_done) begin
                  case (i_rx_data)
                     8'h4C: begin
                        o_cpu_reset <= 1'b1;
                        state       <= LEN_LO;
                     end
                     8'h52: begin
                        if (i_program_end) begin
                           pending <= NAK;
                           state   <= SEND;
                        end else begin
                           o_halt <= 1'b0;
                           state  <= RUN;
                        end
                     end
                     8'h53: begin
                        if (i_program_end) begin
                           pending <= NAK;
                           state   <= SEND;
                        end else begin
                           o_halt <= 1'b0;
                           state  <= STEP;
                        end
                     end
                     8'h50: begin
                        // Pulse lasts one cycle: SEND clears it on its first edge.
                        o_cpu_reset <= 1'b1;
                        pending     <= ACK;
                        state       <= SEND;
                     end
                     default: begin
                        pending <= NAK;
                        state   <= SEND;
                     end
                  endcase
               end
            end
            LEN_LO: begin
               if (i_rx_done) begin
                  length[7:0] <= i_rx_data;
                  state       <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (i_rx_done) begin
                  length <= len_next;
                  if (len_bad) begin
                     o_cpu_reset <= 1'b0;
                     pending     <= NAK;
                     state       <= SEND;
                  end else begin
                     index <= '0;
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               // Completion is detected one cycle after the final write pulse.
               if (index_ext == length) begin
                  o_cpu_reset <= 1'b0;
                  pending     <= ACK;
                  state       <= SEND;
               end else if (i_rx_done) begin
                  o_write_instruction_mem <= 1'b1;
                  o_instruction_mem_addr  <= 32'(index[ADDR_WIDTH-1:0]);
                  o_instruction_mem_data  <= {24'h000000, i_rx_data};
                  index                   <= index + 1'b1;
               end
            end
            RUN: begin
               if (i_program_end) begin
                  o_halt  <= 1'b1;
                  pending <= ACK;
                  state   <= SEND;
               end
            end
            STEP: begin
               o_halt  <= 1'b1;
               pending <= ACK;
               state   <= SEND;
            end
            SEND: begin
               o_cpu_reset <= 1'b0;
               if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
                  o_tx_data  <= pending;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_loader.sv
// Bench for debug_loader: directed command sequences with a scoreboard of
// expected memory writes and transmitted bytes checked by a separate monitor.
module tb_debug_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic        tx_busy = 1'b0;
   logic        program_end = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        halt;
   logic        cpu_reset;
   logic [2:0]  dbg_state;

   int tests = 0;
   int fails = 0;
   int tx_count = 0;
   int halt_low_cnt = 0;
   int cpu_rst_cnt = 0;

   logic [19:0] exp_wr_q[$];
   logic [7:0]  exp_tx_q[$];

   always #5 clk = ~clk;

   debug_loader dut (
      .i_clk                   (clk),
      .i_reset                 (rst_n),
      .i_rx_data               (rx_data),
      .i_rx_done               (rx_done),
      .i_tx_busy               (tx_busy),
      .i_program_end           (program_end),
      .o_tx_data               (tx_data),
      .o_tx_start              (tx_start),
      .o_write_instruction_mem (wr_en),
      .o_instruction_mem_addr  (wr_addr),
      .o_instruction_mem_data  (wr_data),
      .o_halt                  (halt),
      .o_cpu_reset             (cpu_reset),
      .o_debug_state           (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_halt"},      32'(halt), 32'd1);
      check({tag, "_wr_en"},     32'(wr_en), 32'd0);
      check({tag, "_addr"},      wr_addr, 32'd0);
      check({tag, "_data"},      wr_data, 32'd0);
      check({tag, "_tx_start"},  32'(tx_start), 32'd0);
      check({tag, "_tx_data"},   32'(tx_data), 32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
      check({tag, "_state"},     32'(dbg_state), 32'd0);
   endtask

   // Monitor: samples on the falling edge, pops expectations on each output event.
   always @(negedge clk) begin
      logic [19:0] ew;
      logic [7:0]  et;
      if (rst_n) begin
         if (!halt) halt_low_cnt++;
         if (cpu_reset) cpu_rst_cnt++;
         if (wr_en) begin
            if (exp_wr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
               ew = exp_wr_q.pop_front();
               check("wr_addr", wr_addr, 32'(ew[19:8]));
               check("wr_data", wr_data, 32'(ew[7:0]));
            end
            check("wr_cpu_reset", 32'(cpu_reset), 32'd1);
            check("wr_halt", 32'(halt), 32'd1);
         end
         if (tx_start) begin
            tx_count++;
            if (exp_tx_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_tx: got %0h expected no transmit", tx_data);
            end else begin
               et = exp_tx_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(et));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
   endtask

   task automatic wait_tx(input int target, input string name);
      for (int i = 0; i < 100 && tx_count < target; i++) @(posedge clk);
      @(negedge clk);
      check(name, 32'(tx_count), 32'(target));
   endtask

   initial begin
      logic [7:0] prog[4];
      int t;
      prog = '{8'h11, 8'h22, 8'h33, 8'h44};

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("after_reset");

      // Four-byte load
      for (int i = 0; i < 4; i++) exp_wr_q.push_back({12'(i), prog[i]});
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h4C);
      send_byte(8'h04);
      send_byte(8'h00);
      for (int i = 0; i < 4; i++) send_byte(prog[i]);
      check("load_last_cpu_reset", 32'(cpu_reset), 32'd1);
      @(posedge clk);
      #1;
      check("load_done_cpu_reset", 32'(cpu_reset), 32'd0);
      check("load_done_state", 32'(dbg_state), 32'd6);
      wait_tx(t + 1, "load_ack");

      // Zero length
      exp_tx_q.push_back(8'h15);
      t = tx_count;
      send_byte(8'h4C);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_tx(t + 1, "len_zero_nak");

      // Length 0x1001 exceeds the memory
      exp_tx_q.push_back(8'h15);
      t = tx_count;
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'h10);
      wait_tx(t + 1, "len_big_nak");

      // Single-byte load; data byte equal to a command code is still data
      exp_wr_q.push_back({12'd0, 8'h52});
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h52);
      wait_tx(t + 1, "len_one_ack");

      // Full-size load fills every address without wrap
      for (int i = 0; i < 4096; i++) exp_wr_q.push_back({12'(i), 8'(i) ^ 8'h5A});
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h4C);
      send_byte(8'h00);
      send_byte(8'h10);
      for (int i = 0; i < 4096; i++) send_byte(8'(i) ^ 8'h5A);
      wait_tx(t + 1, "len_max_ack");

      // Single step
      halt_low_cnt = 0;
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h53);
      wait_tx(t + 1, "step_ack");
      check("step_halt_low_cycles", 32'(halt_low_cnt), 32'd1);

      // Continuous run, program ends 20 cycles after the command
      halt_low_cnt = 0;
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h52);
      repeat (19) @(posedge clk);
      #1;
      check("run_halt_before_end", 32'(halt), 32'd0);
      program_end = 1'b1;
      @(posedge clk);
      #1;
      check("run_halt_after_end", 32'(halt), 32'd1);
      wait_tx(t + 1, "run_ack");
      check("run_halt_low_cycles", 32'(halt_low_cnt), 32'd20);

      // Run and step rejected once the program has ended
      halt_low_cnt = 0;
      exp_tx_q.push_back(8'h15);
      exp_tx_q.push_back(8'h15);
      t = tx_count;
      send_byte(8'h52);
      wait_tx(t + 1, "run_rejected_nak");
      send_byte(8'h53);
      wait_tx(t + 2, "step_rejected_nak");
      check("rejected_halt_low_cycles", 32'(halt_low_cnt), 32'd0);
      program_end = 1'b0;

      // Unknown command
      exp_tx_q.push_back(8'h15);
      t = tx_count;
      send_byte(8'h41);
      wait_tx(t + 1, "unknown_nak");

      // Pipeline reset under transmitter backpressure; a byte sent in SEND is dropped
      tx_busy = 1'b1;
      cpu_rst_cnt = 0;
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h50);
      send_byte(8'h4C);
      repeat (8) @(posedge clk);
      #1;
      check("bp_no_start_while_busy", 32'(tx_start), 32'd0);
      check("bp_no_tx_while_busy", 32'(tx_count), 32'(t));
      tx_busy = 1'b0;
      @(posedge clk);
      #1;
      check("bp_start_after_release", 32'(tx_start), 32'd1);
      wait_tx(t + 1, "bp_ack");
      check("bp_cpu_reset_pulses", 32'(cpu_rst_cnt), 32'd1);
      check("bp_back_to_idle", 32'(dbg_state), 32'd0);

      // Asynchronous reset in the middle of a load
      exp_wr_q.push_back({12'd0, 8'h11});
      exp_wr_q.push_back({12'd1, 8'h22});
      send_byte(8'h4C);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_load_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cpu_rst_cnt = 0;
      exp_tx_q.push_back(8'h06);
      t = tx_count;
      send_byte(8'h50);
      wait_tx(t + 1, "post_reset_ack");
      check("post_reset_cpu_reset_pulses", 32'(cpu_rst_cnt), 32'd1);

      repeat (5) @(posedge clk);
      check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
